// File: rtl/stage_sequencer.sv
// Multi-cycle LEGv8 stage sequencer: one clock, per-stage enables, pc_src resolve, retire count.
// Optional build macro MEM_SKIP_EN: non-memory instructions bypass the MEMORY state.
module stage_sequencer #(
  parameter int FETCH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             uncond_branch,
  input  logic             branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             instr_latch,
  output logic             reg_read_en,
  output logic             alu_en,
  output logic             mem_en,
  output logic             reg_write_en,
  output logic             pc_update,
  output logic             pc_src,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  // state     | meaning
  // IDLE      | waiting for start
  // FETCH     | instruction memory access, held FETCH_CYCLES cycles
  // DECODE    | register file read
  // EXECUTE   | ALU; branch decision and control flags captured
  // MEMORY    | data memory access, waits for mem_ready on loads/stores
  // WRITEBACK | register write, PC update, retire
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5
  } state_t;

  localparam logic [3:0] FETCH_LOAD = 4'(FETCH_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       fetch_cnt, fetch_cnt_nxt;
  logic             pc_src_nxt;
  logic             mem_op_q, mem_op_nxt;
  logic             writes_rd_q, writes_rd_nxt;
  logic [CNT_W-1:0] retired_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_cnt   <= 4'd0;
      pc_src      <= 1'b0;
      mem_op_q    <= 1'b0;
      writes_rd_q <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_cnt   <= fetch_cnt_nxt;
      pc_src      <= pc_src_nxt;
      mem_op_q    <= mem_op_nxt;
      writes_rd_q <= writes_rd_nxt;
      retired     <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_cnt_nxt = fetch_cnt;
    pc_src_nxt    = pc_src;
    mem_op_nxt    = mem_op_q;
    writes_rd_nxt = writes_rd_q;
    retired_nxt   = retired;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = FETCH;
          fetch_cnt_nxt = FETCH_LOAD;
          pc_src_nxt    = 1'b0;
        end
      end
      FETCH: begin
        if (fetch_cnt == 4'd0) state_nxt = DECODE;
        else fetch_cnt_nxt = fetch_cnt - 4'd1;
      end
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        // Decode flags are captured here so WRITEBACK/MEMORY outputs stay pure state decodes.
        pc_src_nxt    = uncond_branch | (branch & zero);
        mem_op_nxt    = mem_read | mem_write;
        writes_rd_nxt = !(mem_write | branch | uncond_branch);
`ifdef MEM_SKIP_EN
        state_nxt = (mem_read | mem_write) ? MEMORY : WRITEBACK;
`else
        state_nxt = MEMORY;
`endif
      end
      MEMORY: begin
        if (!mem_op_q || mem_ready) state_nxt = WRITEBACK;
      end
      WRITEBACK: begin
        retired_nxt = retired + CNT_W'(1);
        if (stop || !start) begin
          state_nxt = IDLE;
        end else begin
          state_nxt     = FETCH;
          fetch_cnt_nxt = FETCH_LOAD;
          pc_src_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_en     = (state == FETCH);
  assign instr_latch  = (state == FETCH) && (fetch_cnt == 4'd0);
  assign reg_read_en  = (state == DECODE);
  assign alu_en       = (state == EXECUTE);
  assign mem_en       = (state == MEMORY) && mem_op_q;
  assign reg_write_en = (state == WRITEBACK) && writes_rd_q;
  assign pc_update    = (state == WRITEBACK);
  assign busy         = (state != IDLE);
  assign state_o      = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: instruction vector table plus reset/stop/wrap sequences.
module tb_stage_sequencer;
  localparam int FC = 2;
  localparam int CW = 4;
`ifdef MEM_SKIP_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic clk = 1'b0;
  logic reset, start, stop, uncond_branch, branch, mem_read, mem_write, zero, mem_ready;
  logic fetch_en, instr_latch, reg_read_en, alu_en, mem_en, reg_write_en, pc_update, pc_src, busy;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  stage_sequencer #(.FETCH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .uncond_branch(uncond_branch), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .zero(zero), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .instr_latch(instr_latch), .reg_read_en(reg_read_en),
    .alu_en(alu_en), .mem_en(mem_en), .reg_write_en(reg_write_en),
    .pc_update(pc_update), .pc_src(pc_src), .busy(busy), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ub, br, mr, mw, z;
    int   wait_n;
    int   exp_pc_src;
    int   exp_rw;
    int   exp_memcyc;
    int   exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int outs_or();
    return int'({fetch_en, instr_latch, reg_read_en, alu_en, mem_en,
                 reg_write_en, pc_update, pc_src, busy});
  endfunction

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (int'(state_o) != s && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(state_o), s);
  endtask

  task automatic wait_pc_update(input string name);
    int n = 0;
    while (!pc_update && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(pc_update), 1);
  endtask

  // Runs one instruction from IDLE and checks timing, outputs and retire count.
  task automatic run_instr(input vec_t v, input int idx);
    int k = 0, fcnt = 0, latch_k = 0, memcyc = 0, exp_lat;
    int pc_k = 0, rw = 0, ps = 0;
    bit done = 0;
    logic memop;
    memop = v.mr | v.mw;
    exp_lat = memop ? v.exp_lat : v.exp_lat - SKIP;
    uncond_branch = v.ub; branch = v.br; mem_read = v.mr; mem_write = v.mw; zero = v.z;
    mem_ready = memop ? 1'b0 : 1'b1;
    start = 1'b1; stop = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (fetch_en) fcnt++;
      if (instr_latch) latch_k = k;
      if (mem_en) begin
        memcyc++;
        mem_ready = (memcyc == v.wait_n);
      end
      if (pc_update) begin
        done = 1; pc_k = k; rw = int'(reg_write_en); ps = int'(pc_src);
        mem_ready = 1'b0;
      end
    end
    chk($sformatf("v%0d_done", idx), int'(done), 1);
    chk($sformatf("v%0d_latency", idx), pc_k, exp_lat);
    chk($sformatf("v%0d_pc_src", idx), ps, v.exp_pc_src);
    chk($sformatf("v%0d_reg_write_en", idx), rw, v.exp_rw);
    chk($sformatf("v%0d_mem_en_cycles", idx), memcyc, v.exp_memcyc);
    chk($sformatf("v%0d_fetch_cycles", idx), fcnt, FC);
    chk($sformatf("v%0d_instr_latch_cycle", idx), latch_k, FC);
    @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk($sformatf("v%0d_idle_after", idx), int'(state_o), 0);
    chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
    chk($sformatf("v%0d_retired", idx), int'(retired), exp_ret);
  endtask

  initial begin
    //            ub    br    mr    mw    z     wait pcs rw memc lat
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 6};  // ADD
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 1, 3, 8};  // LDUR, 3-cycle memory
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 6};  // STUR, immediate ready
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 6};  // CBZ taken
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 6};  // CBZ not taken
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 6};  // B
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1, 2, 7};  // LDUR, zero ignored

    reset = 1'b0; start = 1'b0; stop = 1'b0; uncond_branch = 1'b0; branch = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state_o), 0);
    chk("reset_outputs", outs_or(), 0);
    chk("reset_retired", int'(retired), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_hold_no_start", int'(state_o), 0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      run_instr(vecs[i], i);
    end

    // Back-to-back: taken branch then ADD; stop raised during DECODE of the ADD.
    @(negedge clk);
    uncond_branch = 1'b1; branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_ready = 1'b0; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    wait_pc_update("b2b_first_wb");
    chk("b2b_first_pc_src", int'(pc_src), 1);
    @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk("b2b_refetch", int'(state_o), 1);
    chk("b2b_pc_src_cleared", int'(pc_src), 0);
    chk("b2b_retired", int'(retired), exp_ret);
    uncond_branch = 1'b0;
    wait_state(2, "stop_reach_decode");
    stop = 1'b1;
    wait_pc_update("stop_wb");
    chk("stop_reg_write_en", int'(reg_write_en), 1);
    @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk("stop_idle", int'(state_o), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_retired", int'(retired), exp_ret);
    stop = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("stop_stays_idle", int'(state_o), 0);

    // Asynchronous reset in the middle of EXECUTE.
    start = 1'b1;
    wait_state(3, "rst_reach_execute");
    reset = 1'b0;
    #1;
    chk("rst_mid_state", int'(state_o), 0);
    chk("rst_mid_outputs", outs_or(), 0);
    chk("rst_mid_retired", int'(retired), 0);
    exp_ret = 0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_held_outputs", outs_or(), 0);
    reset = 1'b1;

    // Retire counter wrap: 16 instructions on a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      run_instr(vecs[0], 100 + i);
    end
    chk("wrap_final_zero", int'(retired), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
